// File: rtl/final_project_pkg.sv
// Shared definitions for the pixel-plot path: screen geometry, field widths,
// the packed plot entry carried through the FIFO and the arbiter state encoding.
package final_project_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    // One buffered pixel: {x, y, colour}, 18 bits.
    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } plot_entry_t;

    typedef enum logic {
        ST_DRAIN = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // True when the entry addresses a pixel inside the visible screen.
    function automatic logic on_screen(plot_entry_t e);
        return (int'(e.x) < SCREEN_W) && (int'(e.y) < SCREEN_H);
    endfunction

endpackage : final_project_pkg

// File: rtl/plot_arbiter_if.sv
// Lane-side plot request bundle: per-lane valid/ready plus packed pixel fields.
// master = lane drivers, slave = plot_arbiter.
interface plot_arbiter_if
    import final_project_pkg::*;
#(
    parameter int NUM_LANES = 4
);

    logic [NUM_LANES-1:0]          req_valid;
    logic [NUM_LANES-1:0]          req_ready;
    logic [X_W*NUM_LANES-1:0]      req_x;
    logic [Y_W*NUM_LANES-1:0]      req_y;
    logic [COLOUR_W*NUM_LANES-1:0] req_colour;

    modport master (
        output req_valid,
        output req_x,
        output req_y,
        output req_colour,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_x,
        input  req_y,
        input  req_colour,
        output req_ready
    );

endinterface : plot_arbiter_if

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot entries. FIFO_DEPTH must be a power of two (>= 2);
// pointers wrap naturally. Push when full and pop when empty are ignored.
module plot_fifo
    import final_project_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        push,
    input  plot_entry_t                 din,
    input  logic                        pop,
    output plot_entry_t                 dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    plot_entry_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Entry storage: written on an accepted push.
    // NOTE: the storage array has no reset; its contents are don't-care until written, and leaving it unreset lets it map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule : plot_fifo

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin arbiter between lane drawing engines feeding
// vga_adapter through a small FIFO, with a full-screen black clear sweep that
// pre-empts buffered traffic.
// Optional feature: define PLOT_CLIP_EN to discard off-screen entries at pop
// time (pulses 'clipped'); when undefined, entries pass through unchanged.
module plot_arbiter
    import final_project_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    plot_arbiter_if.slave               lanes,
    input  logic                        clear_req,
    output logic                        clear_busy,
    output logic                        plot,
    output logic [X_W-1:0]              x,
    output logic [Y_W-1:0]              y,
    output logic [COLOUR_W-1:0]         colour,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        clipped
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [LANE_W-1:0] last_grant;
    logic [LANE_W-1:0] grant_idx;
    logic [LANE_W-1:0] cand;
    logic              grant_found;

    plot_entry_t       lane_entry [NUM_LANES];
    plot_entry_t       push_entry;
    plot_entry_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              clip_hit;

    state_t            state;
    logic [X_W-1:0]    sweep_x;
    logic [Y_W-1:0]    sweep_y;
    logic [X_W-1:0]    sweep_nx;
    logic [Y_W-1:0]    sweep_ny;
    logic              sweep_last;

    // Unpack each lane's request fields into a plot entry.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_entry[i].x      = lanes.req_x[X_W*i +: X_W];
        assign lane_entry[i].y      = lanes.req_y[Y_W*i +: Y_W];
        assign lane_entry[i].colour = lanes.req_colour[COLOUR_W*i +: COLOUR_W];
    end

    // Round-robin grant: first valid lane searching upward from last_grant+1, only while the FIFO has room.
    // NOTE: every signal written here gets a default before any condition, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_found     = 1'b0;
        grant_idx       = last_grant;
        cand            = last_grant;
        lanes.req_ready = '0;
        if (!fifo_full) begin
            for (int k = 1; k <= NUM_LANES; k++) begin
                cand = LANE_W'((int'(last_grant) + k) % NUM_LANES);
                if (!grant_found && lanes.req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        if (grant_found) begin
            lanes.req_ready[grant_idx] = 1'b1;
        end
    end

    // A granted lane is by construction valid, so a grant is a transfer.
    assign push       = grant_found;
    assign push_entry = lane_entry[grant_idx];

    // Pops only in DRAIN, and not on the edge that starts a clear.
    assign pop = (state == ST_DRAIN) && !clear_req && !fifo_empty;

    plot_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (push_entry),
        .pop    (pop),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

`ifdef PLOT_CLIP_EN
    assign clip_hit = !on_screen(head);
`else
    assign clip_hit = 1'b0;
`endif

    // Raster successor of the pixel currently being shown by the sweep.
    always_comb begin
        sweep_nx   = sweep_x + 1'b1;
        sweep_ny   = sweep_y;
        sweep_last = (sweep_x == X_W'(SCREEN_W - 1)) && (sweep_y == Y_W'(SCREEN_H - 1));
        if (sweep_x == X_W'(SCREEN_W - 1)) begin
            sweep_nx = '0;
            sweep_ny = sweep_y + 1'b1;
        end
    end

    // Remember the last granted lane so the next search starts just past it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= LANE_W'(NUM_LANES - 1);
        end else if (push) begin
            last_grant <= grant_idx;
        end
    end

    // Output FSM: replay FIFO entries in DRAIN, emit the black raster sweep in CLEAR.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_DRAIN;
            plot       <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            clear_busy <= 1'b0;
            clipped    <= 1'b0;
            sweep_x    <= '0;
            sweep_y    <= '0;
        end else begin
            clipped <= 1'b0;
            case (state)
                ST_DRAIN: begin
                    if (clear_req) begin
                        // First sweep pixel (0,0) goes out together with clear_busy.
                        state      <= ST_CLEAR;
                        clear_busy <= 1'b1;
                        sweep_x    <= '0;
                        sweep_y    <= '0;
                        plot       <= 1'b1;
                        x          <= '0;
                        y          <= '0;
                        colour     <= '0;
                    end else if (pop) begin
                        x       <= head.x;
                        y       <= head.y;
                        colour  <= head.colour;
                        plot    <= !clip_hit;
                        clipped <= clip_hit;
                    end else begin
                        plot <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (sweep_last) begin
                        state      <= ST_DRAIN;
                        clear_busy <= 1'b0;
                        plot       <= 1'b0;
                    end else begin
                        sweep_x <= sweep_nx;
                        sweep_y <= sweep_ny;
                        plot    <= 1'b1;
                        x       <= sweep_nx;
                        y       <= sweep_ny;
                        colour  <= '0;
                    end
                end
            endcase
        end
    end

endmodule : plot_arbiter

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: table-driven arbitration vectors plus
// directed sequences for latency, fairness, clear sweep, clipping and reset.
module tb_plot_arbiter;
    import final_project_pkg::*;

    localparam int NL = 4;
    localparam int FD = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       clear_req = 1'b0;
    logic       clear_busy;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic [3:0] level;
    logic       clipped;

    plot_arbiter_if #(.NUM_LANES(NL)) lanes ();

    plot_arbiter #(
        .NUM_LANES  (NL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .lanes      (lanes.slave),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .level      (level),
        .clipped    (clipped)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;

    vec_t       vecs [12];
    logic [3:0] prev_rdy;
    int         lg;
    int         npush;
    int         sweep_err;
    int         order_err;
    int         got;
    int         cnt [NL];
    logic       exp_plot;
    logic       exp_clip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int l);
        return 4'b0001 << l;
    endfunction

    function automatic int lane_of(input logic [3:0] v);
        for (int i = 0; i < NL; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_lane(input int l, input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
        lanes.req_x[8*l +: 8]      = xx;
        lanes.req_y[7*l +: 7]      = yy;
        lanes.req_colour[3*l +: 3] = cc;
    endtask

    task automatic set_all(input int k);
        for (int l = 0; l < NL; l++) set_lane(l, 8'(32 + k), 7'(k + 1), 3'(k));
    endtask

    initial begin
        lanes.req_valid = '0;
        lanes.req_x = '0;
        lanes.req_y = '0;
        lanes.req_colour = '0;

        // ---------------- reset values ----------------
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_plot", plot, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_clipped", clipped, 0);
        check("rst_level", level, 0);
        check("rst_ready", lanes.req_ready, 0);
        resetn = 1'b1;
        tick();

        // ---------------- table-driven arbitration ----------------
        for (int l = 0; l < NL; l++) set_lane(l, 8'(10 + l), 7'(20 + l), 3'(l + 1));
        vecs[0]  = '{4'b0000, 4'b0000};
        vecs[1]  = '{4'b1111, 4'b0001};
        vecs[2]  = '{4'b1111, 4'b0010};
        vecs[3]  = '{4'b0101, 4'b0100};
        vecs[4]  = '{4'b0101, 4'b0001};
        vecs[5]  = '{4'b1000, 4'b1000};
        vecs[6]  = '{4'b1001, 4'b0001};
        vecs[7]  = '{4'b0110, 4'b0010};
        vecs[8]  = '{4'b0000, 4'b0000};
        vecs[9]  = '{4'b0001, 4'b0001};
        vecs[10] = '{4'b0000, 4'b0000};
        vecs[11] = '{4'b0000, 4'b0000};
        for (int i = 0; i < 12; i++) begin
            prev_rdy = (i >= 2) ? vecs[i-2].ready : 4'b0000;
            check($sformatf("tbl%0d_plot", i), plot, prev_rdy != 4'b0000);
            if (prev_rdy != 4'b0000) begin
                check($sformatf("tbl%0d_x", i), x, 10 + lane_of(prev_rdy));
                check($sformatf("tbl%0d_y", i), y, 20 + lane_of(prev_rdy));
                check($sformatf("tbl%0d_colour", i), colour, lane_of(prev_rdy) + 1);
            end
            lanes.req_valid = vecs[i].valid;
            #1;
            check($sformatf("tbl%0d_ready", i), lanes.req_ready, vecs[i].ready);
            tick();
        end
        lanes.req_valid = '0;
        // last grant is now lane 0

        // ---------------- single request, push-to-plot latency ----------------
        set_lane(2, 8'd19, 7'd40, 3'd5);
        lanes.req_valid = 4'b0100;
        #1;
        check("lat_ready", lanes.req_ready, 4'b0100);
        tick();
        lanes.req_valid = '0;
        check("lat_n1_plot", plot, 0);
        check("lat_n1_level", level, 1);
        tick();
        check("lat_n2_plot", plot, 1);
        check("lat_n2_x", x, 19);
        check("lat_n2_y", y, 40);
        check("lat_n2_colour", colour, 5);
        check("lat_n2_level", level, 0);
        tick();

        // ---------------- fairness: all lanes valid for 100 cycles ----------------
        lg = 2;
        order_err = 0;
        for (int l = 0; l < NL; l++) cnt[l] = 0;
        lanes.req_valid = 4'b1111;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (lanes.req_ready !== oh((lg + 1) % NL)) order_err++;
            if (lane_of(lanes.req_ready) >= 0) cnt[lane_of(lanes.req_ready)]++;
            lg = (lg + 1) % NL;
            tick();
        end
        lanes.req_valid = '0;
        check("rr_order_errors", order_err, 0);
        for (int l = 0; l < NL; l++) check($sformatf("rr_count_lane%0d", l), cnt[l], 25);
        repeat (3) tick();
        check("rr_drained_level", level, 0);

        // ---------------- clear sweep with concurrent pushes ----------------
        set_all(0);
        lanes.req_valid = 4'b1111;
        clear_req = 1'b1;
        #1;
        check("clr_ready0", lanes.req_ready, oh((lg + 1) % NL));
        lg = (lg + 1) % NL;
        tick();
        clear_req = 1'b0;
        npush = 1;
        sweep_err = 0;
        for (int p = 0; p < 19200; p++) begin
            if (plot !== 1'b1 || colour !== 3'd0 || x !== 8'(p % 160) ||
                y !== 7'(p / 160) || clear_busy !== 1'b1) sweep_err++;
            clear_req = (p == 5000);
            if (p < 7) begin
                set_all(npush);
                #1;
                check($sformatf("clr_ready%0d", npush), lanes.req_ready, oh((lg + 1) % NL));
                lg = (lg + 1) % NL;
                npush++;
            end else if (p == 7) begin
                #1;
                check("clr_full_ready", lanes.req_ready, 0);
                check("clr_full_level", level, 8);
                lanes.req_valid = '0;
            end
            tick();
        end
        clear_req = 1'b0;
        check("clr_sweep_errors", sweep_err, 0);
        check("clr_busy_fall", clear_busy, 0);

        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (plot === 1'b1) begin
                if (got < 8) begin
                    check($sformatf("drain%0d_x", got), x, 32 + got);
                    check($sformatf("drain%0d_y", got), y, got + 1);
                    check($sformatf("drain%0d_colour", got), colour, got % 8);
                end
                got++;
            end
            tick();
        end
        check("drain_count", got, 8);
        check("drain_level", level, 0);

        // ---------------- off-screen entry ----------------
`ifdef PLOT_CLIP_EN
        exp_plot = 1'b0;
        exp_clip = 1'b1;
`else
        exp_plot = 1'b1;
        exp_clip = 1'b0;
`endif
        set_lane(0, 8'd200, 7'd10, 3'd6);
        lanes.req_valid = 4'b0001;
        #1;
        check("clip_ready", lanes.req_ready, 4'b0001);
        lg = 0;
        tick();
        lanes.req_valid = '0;
        tick();
        check("clip_plot", plot, exp_plot);
        check("clip_pulse", clipped, exp_clip);
        check("clip_level", level, 0);
`ifndef PLOT_CLIP_EN
        check("clip_x", x, 200);
`endif
        tick();
        check("clip_pulse_end", clipped, 0);

        // ---------------- reset mid-sweep with 3 entries buffered ----------------
        set_all(0);
        lanes.req_valid = 4'b1111;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        lanes.req_valid = '0;
        check("rsw_level3", level, 3);
        check("rsw_busy", clear_busy, 1);
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        check("rsw_plot", plot, 0);
        check("rsw_x", x, 0);
        check("rsw_y", y, 0);
        check("rsw_colour", colour, 0);
        check("rsw_clear_busy", clear_busy, 0);
        check("rsw_clipped", clipped, 0);
        check("rsw_level", level, 0);
        tick();
        resetn = 1'b1;
        lanes.req_valid = 4'b1111;
        #1;
        check("rsw_first_grant", lanes.req_ready, 4'b0001);
        tick();
        lanes.req_valid = '0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_plot_arbiter
